bolo_line_writer: RTL and testbench

- Writer side of the bolometer channel-buffer interface.
- Takes the serial ADC sample stream for one bolometer line and splits it into per-channel buffers.
  - Two-channel mode: even samples go to CAN1, odd samples go to CAN2.
  - Single-channel mode: all samples go to CAN1.
- Generates the buffer write strobes and addresses.
- Handshakes line completion with the downstream channel reader/mux via LINE_READY / LINE_ACK.

---
 rtl/bolo_line_writer.sv | 150 +++++++++++++++
 tb/tb_bolo_line_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bolo_line_writer.sv
// bolo_line_writer
//   Writer side of the bolometer channel-buffer interface. Splits the serial ADC
//   sample stream of one bolometer line into per-channel buffers (even samples to
//   CAN1 and odd samples to CAN2 in two-channel mode, all samples to CAN1 in
//   single-channel mode). It then holds LINE_READY until the reader acknowledges.
//
// Ports
//   i_clk               system clock, rising edge
//   i_rst               synchronous active-high reset
//   i_adc_data          ADC sample
//   i_adc_valid         i_adc_data valid this cycle
//   i_line_start        one-cycle pulse, start of a bolometer line
//   i_numb_chan         0 = single channel, 1 = two interleaved channels
//   o_wr_data           registered sample to the buffers
//   o_wr_addr           registered write address shared by both buffers
//   o_wr_en_can1        write strobe, channel 1 buffer
//   o_wr_en_can2        write strobe, channel 2 buffer
//   o_line_ready        line complete, buffers owned by the reader
//   i_line_ack          one-cycle pulse from the reader, buffers consumed
//   o_numb_chan_latched channel mode of the current/last line
//   o_overrun           sticky protocol error flag, cleared only by reset

`ifndef ADC_WIDHT
`define ADC_WIDHT 16
`endif

module bolo_line_writer #(
  parameter int unsigned DATA_W       = `ADC_WIDHT,
  parameter int unsigned PIX_PER_CHAN = 64,
  parameter int unsigned ADDR_W       = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_valid,
  input  logic              i_line_start,
  input  logic              i_numb_chan,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_wr_en_can1,
  output logic              o_wr_en_can2,
  output logic              o_line_ready,
  input  logic              i_line_ack,
  output logic              o_numb_chan_latched,
  output logic              o_overrun
);

  localparam int unsigned KW = ADDR_W + 1;

  // Index of the final sample of a line in each mode.
  localparam logic [KW-1:0] LAST_M0 = KW'(PIX_PER_CHAN - 1);
  localparam logic [KW-1:0] LAST_M1 = KW'(2 * PIX_PER_CHAN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [KW-1:0]     r_k;
  logic              r_mode;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_en_can1;
  logic              r_wr_en_can2;
  logic              r_line_ready;
  logic              r_overrun;

  // A LINE_START during FILL restarts the line in the same cycle, so the sample
  // index and mode used for this cycle's write come from the restart values.
  logic [KW-1:0]     w_k_eff;
  logic              w_mode_eff;
  logic              w_at_end;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_k_eff    = i_line_start ? '0 : r_k;
    w_mode_eff = i_line_start ? i_numb_chan : r_mode;
    w_at_end   = (w_k_eff == (w_mode_eff ? LAST_M1 : LAST_M0));
    w_addr     = w_mode_eff ? w_k_eff[ADDR_W:1] : w_k_eff[ADDR_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_mode       <= 1'b0;
      r_wr_data    <= '0;
      r_wr_addr    <= '0;
      r_wr_en_can1 <= 1'b0;
      r_wr_en_can2 <= 1'b0;
      r_line_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_wr_en_can1 <= 1'b0;
      r_wr_en_can2 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_line_start) begin
            r_state <= S_FILL;
            r_mode  <= i_numb_chan;
            r_k     <= '0;
          end
        end
        S_FILL: begin
          if (i_line_start) begin
            r_overrun <= 1'b1;
            r_mode    <= i_numb_chan;
          end
          if (i_adc_valid) begin
            r_wr_data    <= i_adc_data;
            r_wr_addr    <= w_addr;
            r_wr_en_can1 <= ~w_mode_eff | ~w_k_eff[0];
            r_wr_en_can2 <= w_mode_eff & w_k_eff[0];
            if (w_at_end) begin
              r_state      <= S_DONE;
              r_line_ready <= 1'b1;
              r_k          <= '0;
            end else begin
              r_k <= w_k_eff + 1'b1;
            end
          end else begin
            r_k <= w_k_eff;
          end
        end
        S_DONE: begin
          // Reader still owns the buffers: new data or a new line is an error.
          if (i_adc_valid || i_line_start) begin
            r_overrun <= 1'b1;
          end
          if (i_line_ack) begin
            r_line_ready <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wr_data           = r_wr_data;
  assign o_wr_addr           = r_wr_addr;
  assign o_wr_en_can1        = r_wr_en_can1;
  assign o_wr_en_can2        = r_wr_en_can2;
  assign o_line_ready        = r_line_ready;
  assign o_numb_chan_latched = r_mode;
  assign o_overrun           = r_overrun;

endmodule

// File: tb/tb_bolo_line_writer.sv
module tb_bolo_line_writer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          line_start;
  logic          numb_chan;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en_can1;
  logic          wr_en_can2;
  logic          line_ready;
  logic          line_ack;
  logic          numb_chan_latched;
  logic          overrun;

  int n_checks;
  int n_fail;

  bolo_line_writer #(
    .DATA_W      (DW),
    .PIX_PER_CHAN(4),
    .ADDR_W      (AW)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_adc_data         (adc_data),
    .i_adc_valid        (adc_valid),
    .i_line_start       (line_start),
    .i_numb_chan        (numb_chan),
    .o_wr_data          (wr_data),
    .o_wr_addr          (wr_addr),
    .o_wr_en_can1       (wr_en_can1),
    .o_wr_en_can2       (wr_en_can2),
    .o_line_ready       (line_ready),
    .i_line_ack         (line_ack),
    .o_numb_chan_latched(numb_chan_latched),
    .o_overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          ls;
    logic          nc;
    logic          ack;
    logic          e1;
    logic          e2;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          er;
    logic          el;
    logic          eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [DW-1:0] d, input logic ls, input logic nc,
                     input logic ack, input logic e1, input logic e2, input logic [AW-1:0] ea,
                     input logic [DW-1:0] ed, input logic er, input logic el, input logic eo);
    vec_t t;
    t.valid = v; t.data = d; t.ls = ls; t.nc = nc; t.ack = ack;
    t.e1 = e1; t.e2 = e2; t.ea = ea; t.ed = ed; t.er = er; t.el = el; t.eo = eo;
    vecs.push_back(t);
  endtask

  // Compare all outputs as {en1,en2,addr,data,ready,latched,overrun}.
  task automatic check(input string name, input logic e1, input logic e2, input logic [AW-1:0] ea,
                       input logic [DW-1:0] ed, input logic er, input logic el, input logic eo);
    logic [AW+DW+4:0] act;
    logic [AW+DW+4:0] exp;
    act = {wr_en_can1, wr_en_can2, wr_addr, wr_data, line_ready, numb_chan_latched, overrun};
    exp = {e1, e2, ea, ed, er, el, eo};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got en1=%b en2=%b addr=%0d data=%h rdy=%b lat=%b ovr=%b, want en1=%b en2=%b addr=%0d data=%h rdy=%b lat=%b ovr=%b",
               name, wr_en_can1, wr_en_can2, wr_addr, wr_data, line_ready, numb_chan_latched,
               overrun, e1, e2, ea, ed, er, el, eo);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ls, input logic nc,
                       input logic ack, input logic r);
    @(negedge clk);
    adc_valid = v; adc_data = d; line_start = ls; numb_chan = nc; line_ack = ack; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; adc_valid = 1'b0; adc_data = '0; line_start = 1'b0; numb_chan = 1'b0;
    line_ack = 1'b0;

    // Test 1: mode 1, eight samples interleaved, then ACK.
    add(0, 8'h00, 1, 1, 0,  0, 0, 0, 8'h00, 0, 1, 0);
    add(1, 8'h10, 0, 1, 0,  1, 0, 0, 8'h10, 0, 1, 0);
    add(1, 8'h11, 0, 1, 0,  0, 1, 0, 8'h11, 0, 1, 0);
    add(1, 8'h12, 0, 1, 0,  1, 0, 1, 8'h12, 0, 1, 0);
    add(1, 8'h13, 0, 1, 0,  0, 1, 1, 8'h13, 0, 1, 0);
    add(1, 8'h14, 0, 1, 0,  1, 0, 2, 8'h14, 0, 1, 0);
    add(1, 8'h15, 0, 1, 0,  0, 1, 2, 8'h15, 0, 1, 0);
    add(1, 8'h16, 0, 1, 0,  1, 0, 3, 8'h16, 0, 1, 0);
    add(1, 8'h17, 0, 1, 0,  0, 1, 3, 8'h17, 1, 1, 0);
    add(0, 8'h00, 0, 1, 0,  0, 0, 3, 8'h17, 1, 1, 0);
    add(0, 8'h00, 0, 1, 1,  0, 0, 3, 8'h17, 0, 1, 0);
    // IDLE ignores ADC_VALID and LINE_ACK.
    add(1, 8'h55, 0, 1, 0,  0, 0, 3, 8'h17, 0, 1, 0);
    add(0, 8'h00, 0, 1, 1,  0, 0, 3, 8'h17, 0, 1, 0);
    // Test 2: mode 0 with gaps between valids.
    add(0, 8'h00, 1, 0, 0,  0, 0, 3, 8'h17, 0, 0, 0);
    add(1, 8'hA0, 0, 0, 0,  1, 0, 0, 8'hA0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0,  0, 0, 0, 8'hA0, 0, 0, 0);
    add(1, 8'hA1, 0, 0, 0,  1, 0, 1, 8'hA1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0,  0, 0, 1, 8'hA1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0,  0, 0, 1, 8'hA1, 0, 0, 0);
    add(1, 8'hA2, 0, 0, 0,  1, 0, 2, 8'hA2, 0, 0, 0);
    add(1, 8'hA3, 0, 0, 0,  1, 0, 3, 8'hA3, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0,  0, 0, 3, 8'hA3, 1, 0, 0);
    // Test 3: VALID and LINE_START while DONE.
    add(1, 8'h99, 0, 0, 0,  0, 0, 3, 8'hA3, 1, 0, 1);
    add(0, 8'h00, 1, 1, 0,  0, 0, 3, 8'hA3, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1,  0, 0, 3, 8'hA3, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0,  0, 0, 3, 8'hA3, 0, 0, 1);
    add(1, 8'hB0, 0, 0, 0,  1, 0, 0, 8'hB0, 0, 0, 1);
    add(1, 8'hB1, 0, 0, 0,  1, 0, 1, 8'hB1, 0, 0, 1);
    add(1, 8'hB2, 0, 0, 0,  1, 0, 2, 8'hB2, 0, 0, 1);
    add(1, 8'hB3, 0, 0, 0,  1, 0, 3, 8'hB3, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1,  0, 0, 3, 8'hB3, 0, 0, 1);
    // Test 4: restart after three samples in mode 1.
    add(0, 8'h00, 1, 1, 0,  0, 0, 3, 8'hB3, 0, 1, 1);
    add(1, 8'hC0, 0, 1, 0,  1, 0, 0, 8'hC0, 0, 1, 1);
    add(1, 8'hC1, 0, 1, 0,  0, 1, 0, 8'hC1, 0, 1, 1);
    add(1, 8'hC2, 0, 1, 0,  1, 0, 1, 8'hC2, 0, 1, 1);
    add(0, 8'h00, 1, 1, 0,  0, 0, 1, 8'hC2, 0, 1, 1);
    add(1, 8'hD0, 0, 1, 0,  1, 0, 0, 8'hD0, 0, 1, 1);
    add(1, 8'hD1, 0, 1, 0,  0, 1, 0, 8'hD1, 0, 1, 1);
    add(1, 8'hD2, 0, 1, 0,  1, 0, 1, 8'hD2, 0, 1, 1);
    add(1, 8'hD3, 0, 1, 0,  0, 1, 1, 8'hD3, 0, 1, 1);
    add(1, 8'hD4, 0, 1, 0,  1, 0, 2, 8'hD4, 0, 1, 1);
    add(1, 8'hD5, 0, 1, 0,  0, 1, 2, 8'hD5, 0, 1, 1);
    add(1, 8'hD6, 0, 1, 0,  1, 0, 3, 8'hD6, 0, 1, 1);
    add(1, 8'hD7, 0, 1, 0,  0, 1, 3, 8'hD7, 1, 1, 1);
    add(0, 8'h00, 0, 1, 1,  0, 0, 3, 8'hD7, 0, 1, 1);
    // Restart with a sample in the same cycle: becomes k=0 of a mode-0 line.
    add(0, 8'h00, 1, 1, 0,  0, 0, 3, 8'hD7, 0, 1, 1);
    add(1, 8'hE0, 0, 1, 0,  1, 0, 0, 8'hE0, 0, 1, 1);
    add(1, 8'hE1, 0, 1, 0,  0, 1, 0, 8'hE1, 0, 1, 1);
    add(1, 8'hE2, 1, 0, 0,  1, 0, 0, 8'hE2, 0, 0, 1);
    add(1, 8'hE3, 0, 0, 0,  1, 0, 1, 8'hE3, 0, 0, 1);
    add(1, 8'hE4, 0, 0, 0,  1, 0, 2, 8'hE4, 0, 0, 1);
    add(1, 8'hE5, 0, 0, 0,  1, 0, 3, 8'hE5, 1, 0, 1);
    // LINE_START with LINE_ACK in DONE: ACK wins, line not started.
    add(0, 8'h00, 1, 1, 1,  0, 0, 3, 8'hE5, 0, 0, 1);
    add(1, 8'h77, 0, 1, 0,  0, 0, 3, 8'hE5, 0, 0, 1);
    // Test 6: NUMB_CHAN drops mid-line; takes effect on the next line.
    add(0, 8'h00, 1, 1, 0,  0, 0, 3, 8'hE5, 0, 1, 1);
    add(1, 8'hF0, 0, 1, 0,  1, 0, 0, 8'hF0, 0, 1, 1);
    add(1, 8'hF1, 0, 1, 0,  0, 1, 0, 8'hF1, 0, 1, 1);
    add(1, 8'hF2, 0, 0, 0,  1, 0, 1, 8'hF2, 0, 1, 1);
    add(1, 8'hF3, 0, 0, 0,  0, 1, 1, 8'hF3, 0, 1, 1);
    add(1, 8'hF4, 0, 0, 0,  1, 0, 2, 8'hF4, 0, 1, 1);
    add(1, 8'hF5, 0, 0, 0,  0, 1, 2, 8'hF5, 0, 1, 1);
    add(1, 8'hF6, 0, 0, 0,  1, 0, 3, 8'hF6, 0, 1, 1);
    add(1, 8'hF7, 0, 0, 0,  0, 1, 3, 8'hF7, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1,  0, 0, 3, 8'hF7, 0, 1, 1);
    add(0, 8'h00, 1, 0, 0,  0, 0, 3, 8'hF7, 0, 0, 1);
    add(1, 8'h60, 0, 0, 0,  1, 0, 0, 8'h60, 0, 0, 1);
    add(1, 8'h61, 0, 0, 0,  1, 0, 1, 8'h61, 0, 0, 1);
    add(1, 8'h62, 0, 0, 0,  1, 0, 2, 8'h62, 0, 0, 1);
    add(1, 8'h63, 0, 0, 0,  1, 0, 3, 8'h63, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1,  0, 0, 3, 8'h63, 0, 0, 1);

    // Reset state.
    drive(0, 8'h00, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 0, 1);
    check("reset", 0, 0, 0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].ls, vecs[i].nc, vecs[i].ack, 1'b0);
      check($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].ea, vecs[i].ed,
            vecs[i].er, vecs[i].el, vecs[i].eo);
    end

    // Test 5: reset after five samples of a mode-1 line.
    drive(0, 8'h00, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 8'h30 + DW'(i), 0, 1, 0, 0);
    check("pre_rst", 1, 0, 2, 8'h34, 0, 1, 1);
    drive(1, 8'h35, 0, 1, 0, 1);
    check("rst_fill", 0, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 8'h36, 0, 1, 0, 0);
    check("post_rst_v1", 0, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 8'h37, 0, 1, 0, 0);
    check("post_rst_v2", 0, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 8'h40, 1, 1, 0, 0);
    check("post_rst_ls", 0, 0, 0, 8'h00, 0, 1, 0);
    drive(1, 8'h41, 0, 1, 0, 0);
    check("post_rst_s0", 1, 0, 0, 8'h41, 0, 1, 0);

    // Reset while DONE.
    for (int i = 0; i < 7; i++) drive(1, 8'h50 + DW'(i), 0, 1, 0, 0);
    check("done_before_rst", 0, 1, 3, 8'h56, 1, 1, 0);
    drive(0, 8'h00, 0, 1, 0, 1);
    check("rst_done", 0, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 8'h5A, 0, 1, 1, 0);
    check("rst_done_idle", 0, 0, 0, 8'h00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
